spi_slave_fsm: RTL and testbench
================================

// Module: spi_slave_fsm
// PURPOSE
//  Serial front end of the SPI RAM; feeds SPI_ram and returns its read data.
//  - Deserialises MOSI into 10-bit words (din[9:8] = control, din[7:0] = addr/data) and pulses rx_valid.
//  - Serialises the RAM's 8-bit read data back onto MISO after a RD_DATA command.
// PARAMETERS
//  WORD_W  10  width of command word handed to RAM (2 control + 8 payload)
//  DATA_W  8   width of read data returned on MISO
// PORTS
//  clk       in   1       system clock; all logic on posedge
//  rst_n     in   1       asynchronous, active-low reset
//  SS_n      in   1       slave select, active low; frames one transaction
//  MOSI      in   1       serial in, sampled on posedge clk, MSB first
//  MISO      out  1       serial out, MSB first; 0 when not shifting
//  rx_data   out  WORD_W  received word -> RAM din
//  rx_valid  out  1       1-cycle strobe: rx_data complete
//  tx_data   in   DATA_W  RAM dout
//  tx_valid  in   1       RAM read data valid
// BEHAVIOUR
//  Reset: state=IDLE; rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0.
//  Control encoding: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
//  States:
//   IDLE       SS_n=0 -> CHK_CMD.
//   CHK_CMD    samples MOSI (command bit, not stored).
//              0 -> WRITE; 1 & !rd_addr_seen -> READ_ADD; 1 & rd_addr_seen -> READ_DATA.
//   WRITE/READ_ADD
//              shift 10 MOSI bits MSB-first.
//              Edge sampling bit 10 registers rx_data and rx_valid=1 (one cycle only).
//              Then hold until SS_n=1. READ_ADD sets rd_addr_seen on that same edge.
//   READ_DATA  shift 10 bits, rx_valid strobe as above, then wait for tx_valid.
//              Edge sampling tx_valid=1 latches tx_data.
//              MISO = tx_data[7] on the next cycle, then [6]..[0], one bit per clk (8 cycles).
//              Then MISO=0, clear rd_addr_seen, hold until SS_n=1.
//  Latency: rx_valid visible 1 cycle after CHK_CMD + 10 bit cycles (cycle 12 after SS_n fall).
//  rx_data holds its value between strobes. It is forwarded unchanged even if rx_data[9]
//  disagrees with the command bit; the RAM decodes din[9:8].
//  tx_valid is ignored in every state except READ_DATA after its rx_valid strobe,
//  and ignored while shifting out.
//  Abort: SS_n=1 in any state -> IDLE next edge.
//   - Counters cleared, MISO=0.
//   - A partial word produces no rx_valid.
//   - rd_addr_seen keeps its value (cleared only by rst_n or a completed RD_DATA shift-out).
//  Simultaneous: SS_n=1 on the edge of bit 10 -> abort wins, no rx_valid.
//  Reset mid-transfer: immediate return to reset values, regardless of SS_n.
//  Bit counter 4 bits, saturates; never wraps inside a frame.
// STRUCTURE
//  spi_pkg: state enum spi_state_e {IDLE,CHK_CMD,WRITE,READ_ADD,READ_DATA};
//   control localparams WR_ADDR/WR_DATA/RD_ADDR/RD_DATA; WORD_W/DATA_W defaults.
//  Sub-module spi_shift_out: load/enable PISO, DATA_W bits, drives MISO and done.
//  FSM, input shifter and rd_addr_seen stay in spi_slave_fsm.
// TESTING
//  1 SS_n=0, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid=1 for 1 cycle at cycle 12.
//  2 Write 01_0011_1100 after test 1 -> rx_data=10'h13C; RAM mem[8'hA5]=8'h3C.
//  3 Read: cmd 1 + 10_1010_0101 (rx_data=10'h2A5), SS_n=1;
//    then cmd 1 + 11_0000_0000 (rx_data=10'h300), tx_data=8'h3C, tx_valid=1
//    -> MISO 0,0,1,1,1,1,0,0 over 8 cycles; rd_addr_seen cleared.
//  4 SS_n=1 after 6 bits -> no rx_valid, state IDLE next cycle, rx_data unchanged.
//  5 rst_n=0 during MISO shift (bit 3) -> MISO=0, rx_valid=0, rd_addr_seen=0 immediately;
//    next read command goes to READ_ADD.
//  6 tx_valid=1 while in WRITE -> MISO stays 0; SVA: rx_valid never high 2 consecutive cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the SPI RAM.
package spi_pkg;

    localparam int DEF_WORD_W = 10;  // 2 control bits + 8 address/data bits
    localparam int DEF_DATA_W = 8;   // read data returned on MISO
    localparam int CNT_W      = 4;   // received-bit counter width

    // Control field carried in rx_data[9:8]; the RAM decodes it.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_shift_out.sv
// Parallel-in/serial-out shifter that drives MISO MSB first after a load.
// MISO shows the MSB on the cycle after load and returns to 0 once the
// last bit has been held for one cycle; done marks that final edge.
module spi_shift_out
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso,
    output logic              busy,
    output logic              done
);

    localparam int REM_W = $clog2(DATA_W);

    logic [DATA_W-2:0] shreg;
    logic [REM_W-1:0]  remaining;

    // Last bit is on MISO and this edge retires it.
    assign done = busy && (remaining == '0);

    // Load, shift and clear of the outgoing byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso      <= 1'b0;
            busy      <= 1'b0;
            shreg     <= '0;
            remaining <= '0;
        end else if (clear) begin
            miso      <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
        end else if (load) begin
            miso      <= load_data[DATA_W-1];
            shreg     <= load_data[DATA_W-2:0];
            remaining <= REM_W'(DATA_W - 1);
            busy      <= 1'b1;
        end else if (busy) begin
            if (done) begin
                miso <= 1'b0;
                busy <= 1'b0;
            end else begin
                miso      <= shreg[DATA_W-2];
                shreg     <= {shreg[DATA_W-3:0], 1'b0};
                remaining <= remaining - REM_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI into command words for the RAM
// and serialises RAM read data back onto MISO after a RD_DATA command.
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

    spi_state_e        state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] rx_shift;
    logic              rd_addr_seen;
    logic              shifting, word_done, tx_load, tx_busy, tx_done;

    // Strobes derived from the current state; an abort (SS_n high) masks them all.
    always_comb begin
        shifting  = (state inside {WRITE, READ_ADD, READ_DATA}) && !SS_n && (bit_cnt < WORD_CNT);
        word_done = shifting && (bit_cnt == LAST_BIT);
        // Read data is accepted once per read: rd_addr_seen drops after shift-out.
        tx_load   = (state == READ_DATA) && !SS_n && (bit_cnt == WORD_CNT)
                    && rd_addr_seen && !tx_busy && tx_valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state logic; SS_n high returns to IDLE from anywhere.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (!SS_n) state_next = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)              state_next = IDLE;
                else if (!MOSI)        state_next = WRITE;
                else if (rd_addr_seen) state_next = READ_DATA;
                else                   state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Input shifter, bit counter, received-word register and read-address flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: rx_shift is reset too; it is a handful of flops, not a memory,
            // and a known value keeps partial words deterministic.
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || state == IDLE || state == CHK_CMD) begin
                bit_cnt <= '0;
            end else if (shifting) begin
                // Counter stops at WORD_W, so it never wraps inside a frame.
                bit_cnt  <= bit_cnt + CNT_W'(1);
                rx_shift <= {rx_shift[WORD_W-3:0], MOSI};
                if (word_done) begin
                    rx_data  <= {rx_shift, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD) rd_addr_seen <= 1'b1;
                end
            end
            if (tx_done && !SS_n) rd_addr_seen <= 1'b0;
        end
    end

    spi_shift_out #(
        .DATA_W (DATA_W)
    ) u_shift_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (SS_n),
        .load      (tx_load),
        .load_data (tx_data),
        .miso      (MISO),
        .busy      (tx_busy),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed plus randomized frames for spi_slave_fsm, checked against a
// transaction-level model (read-address flag, last word, expected MISO byte).
module tb_spi_slave_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n, mosi, miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit         m_seen;
    logic [9:0] m_rx_data;

    always #5 clk = ~clk;

    spi_slave_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // rx_valid is a single-cycle strobe.
    assert property (@(posedge clk) disable iff (!rst_n) rx_valid |=> !rx_valid)
    else begin
        miscompares++;
        $error("FAIL rxv_pulse: observed rx_valid high two cycles, expected one");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SS_n-framed transaction. nbits<10 aborts before that bit's edge.
    // cut_at>=0 interrupts the MISO shift-out after that many bits (abort or reset).
    task automatic frame(input bit cmd, input logic [9:0] word, input int nbits,
                         input bit tx_en, input logic [7:0] tx_byte, input int tx_delay,
                         input int cut_at, input bit cut_rst);
        int mode;  // 0 write, 1 read address, 2 read data
        mode = (cmd == 1'b0) ? 0 : (m_seen ? 2 : 1);

        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
        tick();
        check("start_rxv", rx_valid, 0);
        mosi = cmd;
        tick();
        check("cmd_rxv", rx_valid, 0);
        for (int i = 0; i < 10; i++) begin
            mosi = word[9-i]; tx_valid = 1'($urandom); tx_data = 8'($urandom);
            if (i == nbits) begin
                ss_n = 1'b1;
                tick();
                check("abort_rxv", rx_valid, 0);
                check("abort_rxd", rx_data, m_rx_data);
                check("abort_miso", miso, 0);
                return;
            end
            tick();
            check("rx_valid", rx_valid, (i == 9));
            check("shift_miso", miso, 0);
            if (i == 9) begin
                m_rx_data = word;
                check("rx_data", rx_data, m_rx_data);
                if (mode == 1) m_seen = 1'b1;
            end
        end
        tx_valid = 1'b0;
        check("rx_hold", rx_data, m_rx_data);

        if (mode == 2 && tx_en) begin
            for (int d = 0; d < tx_delay; d++) begin
                tick();
                check("wait_miso", miso, 0);
            end
            tx_valid = 1'b1; tx_data = tx_byte;
            tick();
            for (int k = 0; k < 8; k++) begin
                check("miso_bit", miso, tx_byte[7-k]);
                tx_valid = 1'($urandom); tx_data = 8'($urandom);
                if (k == cut_at) begin
                    if (cut_rst) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_miso", miso, 0);
                        check("rst_rxv", rx_valid, 0);
                        check("rst_rxd", rx_data, 0);
                        m_seen = 1'b0; m_rx_data = '0;
                        ss_n = 1'b1; tx_valid = 1'b0;
                        tick();
                        rst_n = 1'b1;
                        tick();
                    end else begin
                        ss_n = 1'b1;
                        tick();
                        check("cut_miso", miso, 0);
                    end
                    return;
                end
                tick();
            end
            check("miso_end", miso, 0);
            m_seen = 1'b0;
            tx_valid = 1'b1; tx_data = 8'hFF;
            tick();
            check("after_miso", miso, 0);
        end else if (tx_en) begin
            // Read data offered where it must be ignored.
            for (int d = 0; d < 3; d++) begin
                tx_valid = 1'b1; tx_data = 8'hFF;
                tick();
                check("ignore_tx", miso, 0);
            end
        end
        tx_valid = 1'b0;
        ss_n = 1'b1;
        tick();
        check("end_miso", miso, 0);
        check("end_rxv", rx_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        m_seen = 1'b0; m_rx_data = '0;
        #12;
        check("reset_rxd", rx_data, 0);
        check("reset_rxv", rx_valid, 0);
        check("reset_miso", miso, 0);
        rst_n = 1'b1;
        tick();

        // Write address 0xA5, then write data 0x3C (tx_valid offered, must be ignored).
        frame(1'b0, 10'h0A5, 10, 1'b1, 8'h00, 0, -1, 1'b0);
        frame(1'b0, 10'h13C, 10, 1'b1, 8'h00, 0, -1, 1'b0);
        // Read address then read data 0x3C.
        frame(1'b1, 10'h2A5, 10, 1'b1, 8'h00, 0, -1, 1'b0);
        frame(1'b1, 10'h300, 10, 1'b1, 8'h3C, 0, -1, 1'b0);
        // Abort after 6 bits, and abort on the edge of bit 10.
        frame(1'b0, 10'h155, 6, 1'b0, 8'h00, 0, -1, 1'b0);
        frame(1'b0, 10'h2AA, 9, 1'b0, 8'h00, 0, -1, 1'b0);
        // Reset during shift-out at bit 3; the next read goes back to READ_ADD.
        frame(1'b1, 10'h2A5, 10, 1'b1, 8'h00, 0, -1, 1'b0);
        frame(1'b1, 10'h300, 10, 1'b1, 8'hB6, 1, 3, 1'b1);
        frame(1'b1, 10'h2A5, 10, 1'b1, 8'h00, 0, -1, 1'b0);
        // Abort during shift-out keeps the read address; the retry still reads.
        frame(1'b1, 10'h300, 10, 1'b1, 8'h5A, 2, 4, 1'b0);
        frame(1'b1, 10'h300, 10, 1'b1, 8'hC3, 0, -1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            bit         cmd;
            logic [9:0] word;
            int         nbits, cut_at;
            cmd    = 1'($urandom);
            word   = 10'($urandom);
            nbits  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            cut_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            frame(cmd, word, nbits, ($urandom_range(0, 3) != 0), 8'($urandom),
                  int'($urandom_range(0, 3)), cut_at, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
